jtag_bsr_param: RTL and testbench

Parametrised boundary-scan register (BSR) that wraps a core's primary inputs and outputs with capture/shift/update cells. It is driven by the TAP controller's single-cycle capture/shift/update enables and uses one TCLK domain, not gated DR clocks. It adds an instruction decode for EXTEST, SAMPLE/PRELOAD, INTEST and BYPASS, a reset-loaded safe state, and a shift-position counter with a wrap flag for bench and BIST sequencing.

---
 rtl/jtag_bsr_param.sv | 139 +++++++++++++
 tb/tb_jtag_bsr_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_bsr_param.sv
// Parametrised boundary-scan register.
// Input cells sit between the device pins and the core inputs; output cells sit
// between the core outputs and the device pins. One serial chain runs
// TDI -> in[0..N_IN-1] -> out[0..N_OUT-1] -> TDO, or the single bypass flop
// when BYPASS is selected. A shift-position counter with a registered wrap
// pulse tracks how far the active chain has been shifted since the last capture.
module jtag_bsr_param #(
    parameter int               N_IN     = 36,
    parameter int               N_OUT    = 39,
    parameter logic [N_IN-1:0]  SAFE_IN  = '0,
    parameter logic [N_OUT-1:0] SAFE_OUT = '0,
    localparam int              CNT_W    = $clog2(N_IN + N_OUT + 1)
) (
    input  logic             TCLK,
    input  logic             TRST,
    input  logic [1:0]       inst,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic             TDI,
    output logic             TDO,
    input  logic [N_IN-1:0]  pin_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] pin_out,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             chain_wrap
);

    localparam int LEN = N_IN + N_OUT;

    typedef enum logic [1:0] {
        INST_EXTEST  = 2'b00,
        INST_SAMPLE  = 2'b01,
        INST_INTEST  = 2'b10,
        INST_BYPASS  = 2'b11
    } inst_t;

    // Shift flops: r_chain[N_IN-1:0] are the input cells, r_chain[LEN-1:N_IN]
    // the output cells, so r_chain[LEN-1] is the cell nearest TDO.
    logic [LEN-1:0]   r_chain;
    logic             r_byp;
    logic [N_IN-1:0]  r_upd_in;
    logic [N_OUT-1:0] r_upd_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;

    inst_t w_inst;
    logic  w_bypass;
    logic  w_intest;
    logic  w_drive_pins;
    logic  w_shift;
    logic  w_last;

    assign w_inst       = inst_t'(inst);
    assign w_bypass     = (w_inst == INST_BYPASS);
    assign w_intest     = (w_inst == INST_INTEST);
    assign w_drive_pins = (w_inst == INST_EXTEST) || (w_inst == INST_INTEST);
    // Capture has priority: a simultaneous shift request is ignored.
    assign w_shift      = shift_dr && !capture_dr;
    // The shift that would bring the count up to the active chain length.
    assign w_last       = w_bypass ? (r_cnt == '0) : (r_cnt == CNT_W'(LEN - 1));

    // BSR shift flops: capture pins/core outputs, or shift toward TDO; held in BYPASS.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_chain <= '0;
        end else if (!w_bypass) begin
            if (capture_dr) begin
                r_chain <= {core_out, pin_in};
            end else if (w_shift) begin
                r_chain <= {r_chain[LEN-2:0], TDI};
            end
        end
    end

    // Bypass flop: captures 0 and shifts TDI only while BYPASS is selected.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_byp <= 1'b0;
        end else if (w_bypass) begin
            if (capture_dr) begin
                r_byp <= 1'b0;
            end else if (w_shift) begin
                r_byp <= TDI;
            end
        end
    end

    // Update latches: load the pre-edge shift flops, so an update that
    // coincides with a shift sees the data from before that shift.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_upd_in  <= SAFE_IN;
            r_upd_out <= SAFE_OUT;
        end else if (update_dr && !w_bypass) begin
            r_upd_in  <= r_chain[N_IN-1:0];
            r_upd_out <= r_chain[LEN-1:N_IN];
        end
    end

    // Shift-position counter, modulo the active chain length, with a
    // registered one-cycle wrap pulse.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (capture_dr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_shift) begin
            if (w_last) begin
                r_cnt  <= '0;
                r_wrap <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Pin/core muxes follow inst combinationally; SAMPLE and BYPASS are transparent.
    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_in_cell
            assign core_in[gi] = w_intest ? r_upd_in[gi] : pin_in[gi];
        end
        for (gi = 0; gi < N_OUT; gi++) begin : g_out_cell
            assign pin_out[gi] = w_drive_pins ? r_upd_out[gi] : core_out[gi];
        end
    endgenerate

    assign TDO        = w_bypass ? r_byp : r_chain[LEN-1];
    assign shift_cnt  = r_cnt;
    assign chain_wrap = r_wrap;

endmodule

// File: tb/tb_jtag_bsr_param.sv
// Directed bench for jtag_bsr_param with N_IN=4, N_OUT=3, SAFE_OUT=3'b101.
// Chain order is TDI -> in[0..3] -> out[0..2] -> TDO, so the bit visible on
// TDO after a capture is out[2], then out[1], out[0], in[3] .. in[0].
module tb_jtag_bsr_param;

    localparam int NI = 4;
    localparam int NO = 3;
    localparam int CW = $clog2(NI + NO + 1);

    logic          TCLK = 1'b0;
    logic          TRST;
    logic [1:0]    inst;
    logic          capture_dr;
    logic          shift_dr;
    logic          update_dr;
    logic          TDI;
    logic          TDO;
    logic [NI-1:0] pin_in;
    logic [NI-1:0] core_in;
    logic [NO-1:0] core_out;
    logic [NO-1:0] pin_out;
    logic [CW-1:0] shift_cnt;
    logic          chain_wrap;

    int n_tests = 0;
    int n_fail  = 0;

    jtag_bsr_param #(
        .N_IN    (NI),
        .N_OUT   (NO),
        .SAFE_OUT(3'b101)
    ) dut (
        .TCLK      (TCLK),
        .TRST      (TRST),
        .inst      (inst),
        .capture_dr(capture_dr),
        .shift_dr  (shift_dr),
        .update_dr (update_dr),
        .TDI       (TDI),
        .TDO       (TDO),
        .pin_in    (pin_in),
        .core_in   (core_in),
        .core_out  (core_out),
        .pin_out   (pin_out),
        .shift_cnt (shift_cnt),
        .chain_wrap(chain_wrap)
    );

    always #5 TCLK = ~TCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge TCLK);
        #1;
    endtask

    logic [6:0] preload;
    logic [6:0] cap_img;

    initial begin
        TRST = 1'b0; inst = 2'b00; capture_dr = 1'b0; shift_dr = 1'b0;
        update_dr = 1'b0; TDI = 1'b0; pin_in = 4'b1010; core_out = 3'b011;
        preload = 7'b1100110;
        // Captured image {core_out, pin_in}: bit 6 reaches TDO first.
        cap_img = 7'b0111010;

        // ---- Reset state (EXTEST) ----
        step(); step();
        chk("rst_tdo", TDO, 1'b0);
        chk("rst_cnt", shift_cnt, 0);
        chk("rst_wrap", chain_wrap, 1'b0);
        chk("rst_pin_out_safe", pin_out, 3'b101);
        chk("rst_core_in", core_in, 4'b1010);
        TRST = 1'b1;
        step();

        // ---- SAMPLE is transparent ----
        inst = 2'b01;
        #1;
        chk("sample_pin_out", pin_out, 3'b011);

        // ---- SAMPLE capture, then shift in the PRELOAD pattern ----
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        chk("cap_cnt", shift_cnt, 0);
        for (int k = 0; k < 7; k++) begin
            TDI = preload[6-k];
            shift_dr = 1'b1;
            chk($sformatf("sample_tdo_%0d", k), TDO, cap_img[6-k]);
            step();
            chk($sformatf("sample_cnt_%0d", k), shift_cnt, (k + 1) % 7);
            chk($sformatf("sample_wrap_%0d", k), chain_wrap, (k == 6) ? 1'b1 : 1'b0);
        end
        shift_dr = 1'b0;
        step();
        chk("wrap_one_cycle", chain_wrap, 1'b0);

        // ---- PRELOAD: update, then EXTEST drives the preloaded output cells ----
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
        chk("preload_sample_pin_out", pin_out, 3'b011);
        inst = 2'b00;
        #1;
        chk("extest_pin_out", pin_out, 3'b110);
        chk("extest_core_in", core_in, 4'b1010);
        inst = 2'b01;
        #1;
        chk("back_sample_pin_out", pin_out, 3'b011);

        // ---- INTEST: core_in from update latches regardless of pins ----
        inst = 2'b10;
        #1;
        chk("intest_core_in", core_in, 4'b0110);
        pin_in = 4'b0001;
        #1;
        chk("intest_core_in_pin_chg", core_in, 4'b0110);
        chk("intest_pin_out", pin_out, 3'b110);
        core_out = 3'b100;
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        chk("intest_cap_tdo", TDO, 1'b1);
        shift_dr = 1'b1; TDI = 1'b1;
        step();
        shift_dr = 1'b0;
        chk("intest_shift_tdo", TDO, 1'b0);
        chk("intest_shift_cnt", shift_cnt, 1);

        // ---- capture and shift together: capture only ----
        capture_dr = 1'b1; shift_dr = 1'b1; TDI = 1'b1;
        step();
        capture_dr = 1'b0; shift_dr = 1'b0;
        chk("capshift_tdo", TDO, 1'b1);
        chk("capshift_cnt", shift_cnt, 0);
        chk("capshift_wrap", chain_wrap, 1'b0);

        // ---- update with shift: latches take pre-shift chain 1000001 ----
        shift_dr = 1'b1; update_dr = 1'b1; TDI = 1'b0;
        step();
        shift_dr = 1'b0; update_dr = 1'b0;
        chk("updshift_pin_out", pin_out, 3'b100);
        chk("updshift_core_in", core_in, 4'b0001);
        chk("updshift_cnt", shift_cnt, 1);

        // ---- BYPASS: one-cycle delay, wrap on every shift ----
        inst = 2'b11;
        #1;
        chk("byp_pin_out", pin_out, 3'b100);
        chk("byp_core_in", core_in, 4'b0001);
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        chk("byp_cap_tdo", TDO, 1'b0);
        chk("byp_cap_cnt", shift_cnt, 0);
        shift_dr = 1'b1;
        TDI = 1'b1;
        step();
        chk("byp_tdo_1", TDO, 1'b1);
        chk("byp_wrap_1", chain_wrap, 1'b1);
        TDI = 1'b0;
        step();
        chk("byp_tdo_2", TDO, 1'b0);
        chk("byp_wrap_2", chain_wrap, 1'b1);
        TDI = 1'b1;
        step();
        chk("byp_tdo_3", TDO, 1'b1);
        chk("byp_wrap_3", chain_wrap, 1'b1);
        chk("byp_cnt", shift_cnt, 0);
        shift_dr = 1'b0;
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
        chk("byp_wrap_idle", chain_wrap, 1'b0);
        inst = 2'b00;
        #1;
        chk("byp_update_held", pin_out, 3'b100);

        // ---- BSR untouched by bypass traffic: chain still 0000010 ----
        inst = 2'b01;
        #1;
        chk("post_byp_tdo", TDO, 1'b0);
        update_dr = 1'b1;
        step();
        update_dr = 1'b0;
        inst = 2'b10;
        #1;
        chk("post_byp_core_in", core_in, 4'b0010);
        chk("post_byp_pin_out", pin_out, 3'b000);

        // ---- TRST after 3 of 7 shifts ----
        inst = 2'b01; pin_in = 4'b1010; core_out = 3'b011;
        capture_dr = 1'b1;
        step();
        capture_dr = 1'b0;
        shift_dr = 1'b1; TDI = 1'b1;
        step(); step(); step();
        chk("pre_trst_cnt", shift_cnt, 3);
        shift_dr = 1'b0;
        inst = 2'b00;
        #2;
        TRST = 1'b0;
        #1;
        chk("trst_tdo", TDO, 1'b0);
        chk("trst_cnt", shift_cnt, 0);
        chk("trst_wrap", chain_wrap, 1'b0);
        chk("trst_pin_out", pin_out, 3'b101);
        inst = 2'b10;
        #1;
        chk("trst_core_in", core_in, 4'b0000);
        inst = 2'b01;
        #1;
        chk("trst_sample_pin_out", pin_out, 3'b011);
        step();
        TRST = 1'b1;
        shift_dr = 1'b1; TDI = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("after_trst_wrap_%0d", k), chain_wrap, 1'b0);
        end
        shift_dr = 1'b0;
        chk("after_trst_cnt", shift_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
